// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: tracks balls and BCD score, paces pauses through the
// external round timer, and freezes motion outside of active play.
module pong_game_ctrl #(
    parameter int NBALLS   = 3,
    parameter int TICK_DIV = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] btn,
    input  logic       refr_tick,
    input  logic       hit,
    input  logic       miss,
    input  logic       timer_up,
    output logic       timer_start,
    output logic       timer_tick,
    output logic       gra_still,
    output logic [1:0] state,
    output logic [1:0] balls,
    output logic [3:0] score_d1,
    output logic [3:0] score_d0
);

    typedef enum logic [1:0] {NEWGAME = 2'd0, PLAY = 2'd1, NEWBALL = 2'd2, OVER = 2'd3} state_t;

    localparam logic [1:0] BALLS_INIT = 2'(NBALLS);
    localparam logic [7:0] DIV_LAST   = 8'(TICK_DIV - 1);

    state_t     state_reg, state_next;
    logic [1:0] balls_next;
    logic [3:0] d1_next, d0_next;
    logic [7:0] div_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            div_cnt    <= '0;
            timer_tick <= 1'b0;
        end else begin
            timer_tick <= refr_tick && (div_cnt == DIV_LAST);
            if (refr_tick)
                div_cnt <= (div_cnt == DIV_LAST) ? 8'd0 : div_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= NEWGAME;
            balls     <= BALLS_INIT;
            score_d1  <= 4'd0;
            score_d0  <= 4'd0;
        end else begin
            state_reg <= state_next;
            balls     <= balls_next;
            score_d1  <= d1_next;
            score_d0  <= d0_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        balls_next  = balls;
        d1_next     = score_d1;
        d0_next     = score_d0;
        timer_start = 1'b0;
        case (state_reg)
            NEWGAME: begin
                if (btn != 2'b00) begin
                    state_next = PLAY;
                    balls_next = BALLS_INIT - 2'd1;
                    d1_next    = 4'd0;
                    d0_next    = 4'd0;
                end
            end
            PLAY: begin
                // A miss in the same cycle as a hit wins; the hit is dropped.
                if (miss) begin
                    timer_start = reset;
                    if (balls == 2'd0) begin
                        state_next = OVER;
                    end else begin
                        state_next = NEWBALL;
                        balls_next = balls - 2'd1;
                    end
                end else if (hit) begin
                    if (score_d0 == 4'd9) begin
                        d0_next = 4'd0;
                        d1_next = (score_d1 == 4'd9) ? 4'd0 : score_d1 + 4'd1;
                    end else begin
                        d0_next = score_d0 + 4'd1;
                    end
                end
            end
            NEWBALL: begin
                if (timer_up && (btn != 2'b00))
                    state_next = PLAY;
            end
            OVER: begin
                if (timer_up) begin
                    state_next = NEWGAME;
                    balls_next = BALLS_INIT;
                end
            end
            default: state_next = NEWGAME;
        endcase
    end

    assign state     = state_reg;
    assign gra_still = (state_reg != PLAY);

endmodule
